// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encodings, frame bit counts and baud divider derivation.
// Defining UART_RX_PARITY_EN adds one even-parity bit to the frame.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

  // Clocks per bit period; the baud counter runs 0..result-1.
  function automatic logic [15:0] baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return 16'(clk_freq / bps);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect; 2 clk latency, no backpressure.
// No edge is reported until the line has been genuinely observed high after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic       rxd_meta;
  logic       rxd_d;
  logic [1:0] warm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_d    <= 1'b0;
      warm     <= 2'b00;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_s    <= rxd_meta;
      warm     <= {warm[0], 1'b1};
      // Reset values of the chain are not line history, so mask them out.
      rxd_d    <= rxd_s & warm[1];
    end
  end

  assign rxd_fall = rxd_d & ~rxd_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN), mid-bit sampling, done/err pulse one clk after stop sample.
// Returns to idle at the stop-bit sample point so a following start edge half a bit later is accepted.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_err,
  output logic       uart_rx_busy
);

  localparam logic [15:0] BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam logic [15:0] SAMPLE_PT    = BAUD_CNT_MAX >> 1;
  localparam logic [15:0] BIT_LAST     = BAUD_CNT_MAX - 16'd1;
  localparam logic [2:0]  BIT_CNT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0]  ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0]  ST_AFTER_DATA = ST_STOP;
`endif

  logic        rxd_s;
  logic        rxd_fall;
  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        sample;
  logic        bit_end;
  logic        par_err;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rxd (uart_rxd),
    .rxd_s    (rxd_s),
    .rxd_fall (rxd_fall)
  );

  assign sample       = (baud_cnt == SAMPLE_PT);
  assign bit_end      = (baud_cnt == BIT_LAST);
  assign uart_rx_busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (state == ST_PARITY && sample) begin
      par_bit <= rxd_s;
    end
  end

  // Even parity: data plus parity bit must hold an even number of ones.
  assign par_err = (^shift) ^ par_bit;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      baud_cnt     <= 16'd0;
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      uart_rx_data <= 8'h00;
      uart_rx_done <= 1'b0;
      uart_rx_err  <= 1'b0;
    end else begin
      uart_rx_done <= 1'b0;
      uart_rx_err  <= 1'b0;

      if (state == ST_IDLE || bit_end) begin
        baud_cnt <= 16'd0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (rxd_fall) begin
            state   <= ST_START;
            bit_cnt <= 3'd0;
          end
        end
        ST_START: begin
          if (sample && rxd_s) begin
            state <= ST_IDLE;
          end else if (bit_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shift <= {rxd_s, shift[7:1]};
          end
          if (bit_end) begin
            if (bit_cnt == BIT_CNT_LAST) begin
              state <= ST_AFTER_DATA;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (sample) begin
            state <= ST_IDLE;
            if (rxd_s && !par_err) begin
              uart_rx_data <= shift;
              uart_rx_done <= 1'b1;
            end else begin
              uart_rx_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model predicts each done/err pulse (kind, data, arrival cycle)
// and the held output byte; a per-cycle monitor compares the DUT against it.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 50000000;
  localparam int unsigned UART_BPS = 115200;
  localparam int BIT  = 434;
  localparam int HALF = 217;
  localparam int TOL  = 5;
`ifdef UART_RX_PARITY_EN
  localparam int BITS_BEFORE_STOP = 10;
`else
  localparam int BITS_BEFORE_STOP = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       uart_rx_err;
  logic       uart_rx_busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (uart_rxd),
    .uart_rx_data (uart_rx_data),
    .uart_rx_done (uart_rx_done),
    .uart_rx_err  (uart_rx_err),
    .uart_rx_busy (uart_rx_busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       expq[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_data = 8'h00;
  int         done_seen = 0;
  int         err_seen = 0;
  int         busy_run = 0;
  int         last_busy_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Per-cycle monitor against the frame-level model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {23'd0, uart_rx_data, uart_rx_done, uart_rx_err, uart_rx_busy}, 32'd0);
      model_data = 8'h00;
      busy_run   = 0;
    end else begin
      check("done_err_exclusive", 32'(uart_rx_done & uart_rx_err), 32'd0);
      if (uart_rx_done || uart_rx_err) begin
        if (expq.size() == 0) begin
          check("spurious_pulse", {30'd0, uart_rx_done, uart_rx_err}, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("pulse_kind", {30'd0, uart_rx_done, uart_rx_err}, e.is_err ? 32'd1 : 32'd2);
          check_range("pulse_time", cyc, e.due - TOL, e.due + TOL);
          if (!e.is_err) model_data = e.data;
        end
        if (uart_rx_done) done_seen++;
        if (uart_rx_err) err_seen++;
      end else if (expq.size() > 0 && cyc > expq[0].due + TOL) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_missing: got none, expected %s data 0x%0h by cycle %0d",
                 expq[0].is_err ? "err" : "done", expq[0].data, expq[0].due + TOL);
        void'(expq.pop_front());
      end
      check("data_hold", 32'(uart_rx_data), 32'(model_data));
      if (uart_rx_busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
    end
  end

  task automatic send_bit(input logic b);
    uart_rxd = b;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Pulse arrives ~4 clk after the line edge (sync + edge detect + register) plus the stop sample offset.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
    exp_t e;
    e.is_err = !(stop && !par_flip);
    e.data   = b;
    e.due    = cyc + BITS_BEFORE_STOP * BIT + HALF + 4;
    expq.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    idle(20);

    send_byte(8'hA5, 1'b1, 1'b0);
    idle(50);
    check("a5_data", 32'(uart_rx_data), 32'h000000A5);
    check("a5_done_count", done_seen, 1);
    check_range("a5_busy_len", last_busy_len, (BITS_BEFORE_STOP * BIT) + 214, (BITS_BEFORE_STOP * BIT) + 222);

    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    idle(50);
    check("b2b_data", 32'(uart_rx_data), 32'h000000C3);
    check("b2b_done_count", done_seen, 3);

    uart_rxd = 1'b0;
    repeat (100) @(posedge clk);
    idle(BIT);
    check("glitch_busy", 32'(uart_rx_busy), 32'd0);
    check("glitch_done_count", done_seen, 3);
    check("glitch_err_count", err_seen, 0);

    send_byte(8'h55, 1'b0, 1'b0);
    idle(50);
    check("badstop_err_count", err_seen, 1);
    check("badstop_done_count", done_seen, 3);
    check("badstop_data_kept", 32'(uart_rx_data), 32'h000000C3);

    // Reset during bit 4 of 8'hF0, released with the line held low.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (HALF) @(posedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_data", 32'(uart_rx_data), 32'd0);
    check("rst_busy", 32'(uart_rx_busy), 32'd0);
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    repeat (600) @(posedge clk);
    check("low_after_reset_busy", 32'(uart_rx_busy), 32'd0);
    idle(30);
    send_byte(8'h0F, 1'b1, 1'b0);
    idle(50);
    check("after_reset_data", 32'(uart_rx_data), 32'h0000000F);
    check("after_reset_done_count", done_seen, 4);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h81, 1'b1, 1'b0);
    idle(50);
    check("par_ok_data", 32'(uart_rx_data), 32'h00000081);
    check("par_ok_done_count", done_seen, 5);
    send_byte(8'h81, 1'b1, 1'b1);
    idle(50);
    check("par_bad_err_count", err_seen, 2);
    check("par_bad_done_count", done_seen, 5);
`endif

    idle(2 * BIT);
    check("expect_queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz, SHALL be supported.
REQ-002 Parameter UART_BPS, default 115200, line baud rate, SHALL be supported.
REQ-003 Port clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-006 Port uart_rx_data  output  8  last received byte, LSB received first.
REQ-007 Port uart_rx_done  output  1  one-clk pulse: uart_rx_data is valid and newly updated.
REQ-008 Port uart_rx_err  output  1  one-clk pulse: frame (or parity) error.
REQ-009 Port uart_rx_busy  output  1  high while a frame is being received.

Function
REQ-010 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-011 BAUD_CNT_MAX SHALL equal CLK_FREQ/UART_BPS (integer divide); baud counter 16 bits, counting 0..BAUD_CNT_MAX-1 then wrapping to 0.
REQ-012 Sample point SHALL be baud_cnt == BAUD_CNT_MAX/2 within each bit period.
REQ-013 States SHALL be IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-014 IDLE -> START on a synchronized falling edge (1 then 0); baud_cnt cleared to 0 at that transition.
REQ-015 START: if the start-bit sample is 1 (glitch), return to IDLE with no done/err pulse; if 0, proceed to DATA at the end of that bit period.
REQ-016 DATA: 8 samples at consecutive sample points, shifted in LSB first; bit counter 0..7; move on after the 8th bit period ends.
REQ-017 STOP: at the stop-bit sample point the FSM SHALL return to IDLE immediately (not at bit end), so a start edge from half a bit later is accepted.
REQ-018 Stop sample 1 and no error: uart_rx_data updated and uart_rx_done high for exactly one clk, on the cycle after the sample edge.
REQ-019 Stop sample 0: uart_rx_err high for one clk, same timing; uart_rx_data SHALL hold its previous value; uart_rx_done stays low.
REQ-020 uart_rx_done and uart_rx_err SHALL never be high in the same cycle.
REQ-021 uart_rx_busy SHALL be high in every state except IDLE.
REQ-022 A falling edge during START/DATA/STOP SHALL be ignored; only IDLE detects start edges.
REQ-023 uart_rx_data SHALL remain stable between done pulses.

Reset
REQ-024 On rst_n low, at any time including mid-frame: FSM to IDLE; counters 0; synchronizer flops 1; uart_rx_data 8'h00; uart_rx_done, uart_rx_err, uart_rx_busy 0.
REQ-025 After reset release, a line already low SHALL NOT start a frame until a 1-to-0 edge is seen.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is start, 8 data, even-parity bit, stop; PARITY state samples one bit; parity mismatch OR stop=0 SHALL give uart_rx_err and no done.
REQ-027 Macro undefined: 10-bit frame, PARITY state and its logic absent; behaviour as REQ-013..REQ-023.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encodings, the BAUD_CNT_MAX derivation, and the frame bit-count constants, for reuse by the transmitter.
REQ-029 Sub-module uart_rx_sync SHALL hold the 2-flop synchronizer and falling-edge detector (outputs: rxd_s, rxd_fall).

Verification (CLK_FREQ=50000000, UART_BPS=115200, BAUD_CNT_MAX=434, sample at 217)
REQ-030 Send 8'hA5, stop=1 -> one done pulse, uart_rx_data=8'hA5, err=0, busy high ~9.5 bit periods (~4123 clk).
REQ-031 Send 8'h3C then 8'hC3 back-to-back, no idle gap -> two done pulses, data 8'h3C then 8'hC3.
REQ-032 Low glitch of 100 clk on idle line -> no done, no err, busy returns low within one bit period; line stays 1.
REQ-033 Send 8'h55 with stop bit forced 0 -> one err pulse, no done, uart_rx_data keeps prior value.
REQ-034 Assert rst_n low at bit 4 of 8'hF0, release, then send 8'h0F -> all outputs 0 during reset; next done carries 8'h0F.
REQ-035 With UART_RX_PARITY_EN: 8'h81 with parity 0 -> done, data 8'h81; same byte with parity 1 -> err, no done.
